// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_add_pkg;

    // Sequencer states: waiting for operands, stepping bits, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit-counter width, never narrower than one bit (WIDTH=1 still needs a flop).
    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell used as the bit step of the serial adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic sum_o,
    output logic co_o
);

    assign sum_o = a_i ^ b_i ^ ci_i;
    assign co_o  = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit adder: one full_adder cell is reused LSB first, with the
// carry held in a flop between bit steps. Operands and results use valid/ready.
// Optional feature macro: SERIAL_ADD_OVERFLOW_EN adds the out_ovf output
// (signed two's-complement overflow of the sum).
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             busy
`ifdef SERIAL_ADD_OVERFLOW_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int            CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_sr_q, b_sr_q, sum_q;
    logic [WIDTH-1:0] a_sr_d, b_sr_d, sum_d;
    logic             carry_q;
    logic             in_ready_q, out_valid_q, busy_q;
    logic             fa_sum, fa_co;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic             ovf_q;
`endif

    // The single bit step: current LSBs plus the carry flop.
    full_adder u_fa (
        .a_i   (a_sr_q[0]),
        .b_i   (b_sr_q[0]),
        .ci_i  (carry_q),
        .sum_o (fa_sum),
        .co_o  (fa_co)
    );

    // Next shift-register contents for one RUN step; the new sum bit enters at the MSB.
    always_comb begin
        a_sr_d = a_sr_q >> 1;
        b_sr_d = b_sr_q >> 1;
        sum_d  = (sum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));
    end

    // Sequencer FSM with counter, shift registers, carry flop and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVERFLOW_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_sr_q     <= in_a;
                        b_sr_q     <= in_b;
                        carry_q    <= in_carry;
                        cnt_q      <= '0;
                        sum_q      <= '0;
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    a_sr_q  <= a_sr_d;
                    b_sr_q  <= b_sr_d;
                    sum_q   <= sum_d;
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
`ifdef SERIAL_ADD_OVERFLOW_EN
                        // Carry into the MSB is the carry flop before this final step.
                        ovf_q       <= carry_q ^ fa_co;
`endif
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_sum   = sum_q;
    assign out_carry = carry_q;
`ifdef SERIAL_ADD_OVERFLOW_EN
    assign out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer (WIDTH=8 plus a WIDTH=1 instance).
// Overflow checks are compiled in when SERIAL_ADD_OVERFLOW_EN is defined.
module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_carry, out_valid, out_ready, out_carry, busy;
    logic [7:0] in_a, in_b, out_sum;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic       out_ovf;
`endif

    logic       v1_in_valid, v1_in_ready, v1_in_carry, v1_out_valid, v1_out_ready;
    logic       v1_out_carry, v1_busy;
    logic [0:0] v1_in_a, v1_in_b, v1_out_sum;
`ifdef SERIAL_ADD_OVERFLOW_EN
    logic       v1_out_ovf;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_carry  (in_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_carry (out_carry),
        .busy      (busy)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    serial_add_sequencer #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1_in_valid),
        .in_ready  (v1_in_ready),
        .in_a      (v1_in_a),
        .in_b      (v1_in_b),
        .in_carry  (v1_in_carry),
        .out_valid (v1_out_valid),
        .out_ready (v1_out_ready),
        .out_sum   (v1_out_sum),
        .out_carry (v1_out_carry),
        .busy      (v1_busy)
`ifdef SERIAL_ADD_OVERFLOW_EN
        ,
        .out_ovf   (v1_out_ovf)
`endif
    );

    // Stimulus helper: accept one operand set (DUT assumed idle), then wait for
    // out_valid. lat counts edges after the accept edge; returns just after that edge.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         output logic [7:0] s, output logic c, output int lat);
        in_a = a; in_b = b; in_carry = cin; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        s = out_sum;
        c = out_carry;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (out_sum !== 8'h00)  begin errors++; $display("FAIL reset_out_sum got=%h exp=00", out_sum); end
        checks++; if (out_carry !== 1'b0) begin errors++; $display("FAIL reset_out_carry got=%b exp=0", out_carry); end
        checks++; if (v1_in_ready !== 1'b1 || v1_busy !== 1'b0) begin errors++; $display("FAIL reset_w1 got ready=%b busy=%b exp ready=1 busy=0", v1_in_ready, v1_busy); end
    endtask

    task automatic test_basic_add();
        logic [7:0] s; logic c; int lat;
        out_ready = 1'b1;
        do_op(8'h5A, 8'h33, 1'b0, s, c, lat);
        checks++; if (lat !== 8)      begin errors++; $display("FAIL basic_latency got=%0d exp=8", lat); end
        checks++; if (s !== 8'h8D)    begin errors++; $display("FAIL basic_sum got=%h exp=8d", s); end
        checks++; if (c !== 1'b0)     begin errors++; $display("FAIL basic_carry got=%b exp=0", c); end
        checks++; if (busy !== 1'b1)  begin errors++; $display("FAIL basic_busy_done got=%b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_one_cycle got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL basic_ready_after got=%b exp=1", in_ready); end
    endtask

    task automatic test_carry_cases();
        logic [7:0] s; logic c; int lat;
        out_ready = 1'b1;
        do_op(8'hFF, 8'h01, 1'b0, s, c, lat);
        checks++; if (s !== 8'h00 || c !== 1'b1) begin errors++; $display("FAIL wrap_ff_01 got=%h/%b exp=00/1", s, c); end
        @(posedge clk); #1;
        do_op(8'hFF, 8'hFF, 1'b1, s, c, lat);
        checks++; if (s !== 8'hFF || c !== 1'b1) begin errors++; $display("FAIL full_ff_ff_c got=%h/%b exp=ff/1", s, c); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [7:0] s; logic c; int lat;
        out_ready = 1'b0;
        do_op(8'h12, 8'h34, 1'b1, s, c, lat);
        checks++; if (s !== 8'h47 || c !== 1'b0) begin errors++; $display("FAIL bp_result got=%h/%b exp=47/0", s, c); end
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            in_a = 8'hC3; in_b = 8'h3C; in_carry = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (out_sum !== 8'h47 || out_carry !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got sum=%h c=%b rdy=%b vld=%b exp sum=47 c=0 rdy=0 vld=1",
                         i, out_sum, out_carry, in_ready, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b vld=%b busy=%b exp 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] s; logic c; int lat;
        out_ready = 1'b1;
        in_a = 8'hAA; in_b = 8'h55; in_carry = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || out_sum !== 8'h00) begin
            errors++; $display("FAIL midrun_reset got rdy=%b busy=%b vld=%b sum=%h exp 1/0/0/00", in_ready, busy, out_valid, out_sum);
        end
        do_op(8'h10, 8'h20, 1'b0, s, c, lat);
        checks++; if (s !== 8'h30 || c !== 1'b0) begin errors++; $display("FAIL after_reset_add got=%h/%b exp=30/0", s, c); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] av[3], bv[3], es[3];
        logic       cv[3], ec[3];
        logic       acc;
        int nacc, nres, cyc, lat;
        av = '{8'h01, 8'hC8, 8'h0F};
        bv = '{8'h02, 8'h64, 8'hF0};
        cv = '{1'b0, 1'b1, 1'b1};
        es = '{8'h03, 8'h2D, 8'h00};
        ec = '{1'b0, 1'b1, 1'b1};
        nacc = 0; nres = 0; cyc = 0;
        out_ready = 1'b1;
        in_a = av[0]; in_b = bv[0]; in_carry = cv[0]; in_valid = 1'b1;
        while (nres < 3 && cyc < 200) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                checks++;
                if (out_sum !== es[nres] || out_carry !== ec[nres]) begin
                    errors++;
                    $display("FAIL b2b_result idx=%0d got=%h/%b exp=%h/%b", nres, out_sum, out_carry, es[nres], ec[nres]);
                end
                nres++;
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                nacc++;
                if (nacc < 3) begin
                    in_a = av[nacc]; in_b = bv[nacc]; in_carry = cv[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (nres !== 3 || nacc !== 3) begin errors++; $display("FAIL b2b_count got res=%0d acc=%0d exp 3/3", nres, nacc); end
        @(posedge clk); #1;

        // WIDTH=1 instance: RUN lasts one cycle.
        v1_out_ready = 1'b1;
        v1_in_a = 1'b1; v1_in_b = 1'b1; v1_in_carry = 1'b1; v1_in_valid = 1'b1;
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        lat = 0;
        while (!v1_out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat !== 1) begin errors++; $display("FAIL w1_latency got=%0d exp=1", lat); end
        checks++; if (v1_out_sum !== 1'b1 || v1_out_carry !== 1'b1) begin
            errors++; $display("FAIL w1_sum got=%b/%b exp=1/1", v1_out_sum, v1_out_carry);
        end
        @(posedge clk); #1;
        v1_in_a = 1'b1; v1_in_b = 1'b0; v1_in_carry = 1'b0; v1_in_valid = 1'b1;
        @(posedge clk); #1;
        v1_in_valid = 1'b0;
        @(posedge clk); #1;
        checks++; if (v1_out_valid !== 1'b1 || v1_out_sum !== 1'b1 || v1_out_carry !== 1'b0) begin
            errors++; $display("FAIL w1_sum2 got vld=%b sum=%b c=%b exp 1/1/0", v1_out_valid, v1_out_sum, v1_out_carry);
        end
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_ADD_OVERFLOW_EN
    task automatic test_overflow();
        logic [7:0] s; logic c; int lat;
        out_ready = 1'b1;
        do_op(8'h7F, 8'h01, 1'b0, s, c, lat);
        checks++; if (out_ovf !== 1'b1 || s !== 8'h80 || c !== 1'b0) begin errors++; $display("FAIL ovf_7f_01 got ovf=%b sum=%h c=%b exp 1/80/0", out_ovf, s, c); end
        @(posedge clk); #1;
        do_op(8'h80, 8'h80, 1'b0, s, c, lat);
        checks++; if (out_ovf !== 1'b1 || s !== 8'h00 || c !== 1'b1) begin errors++; $display("FAIL ovf_80_80 got ovf=%b sum=%h c=%b exp 1/00/1", out_ovf, s, c); end
        @(posedge clk); #1;
        do_op(8'h01, 8'h01, 1'b0, s, c, lat);
        checks++; if (out_ovf !== 1'b0 || s !== 8'h02) begin errors++; $display("FAIL ovf_01_01 got ovf=%b sum=%h exp 0/02", out_ovf, s); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_carry = 1'b0; out_ready = 1'b0;
        v1_in_valid = 1'b0; v1_in_a = '0; v1_in_b = '0; v1_in_carry = 1'b0; v1_out_ready = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_cases();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef SERIAL_ADD_OVERFLOW_EN
        test_overflow();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
